// File: rtl/la_lsu_pkg.sv
// Shared definitions for the la_lsu_mc load/store unit: op field layout,
// access-size encodings, FSM state type and store-lane helper functions.
package la_lsu_pkg;

    // Operation field layout: {store, unsigned, size[1:0]}
    localparam int OP_STORE    = 3;
    localparam int OP_UNSIGNED = 2;
    localparam int OP_SIZE_HI  = 1;
    localparam int OP_SIZE_LO  = 0;

    // Access size encodings (3 is folded onto word)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Fold the reserved size code onto a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_W : size;
    endfunction

    // Byte enables for a store of the given size at byte offset off.
    function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate right-justified store data across every lane it may occupy.
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Natural-alignment test; byte accesses are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/la_lsu_mc_if.sv
// Core-side request/response handshake plus data-SRAM port of la_lsu_mc.
// slave: the load/store unit itself; master: the core and memory around it.
interface la_lsu_mc_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_ale;

    logic              data_sram_req;
    logic              data_sram_wr;
    logic [1:0]        data_sram_size;
    logic [3:0]        data_sram_wstrb;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [31:0]       data_sram_wdata;
    logic              data_sram_addr_ok;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready,
               data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_ale,
               data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready,
               data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_ale,
               data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/la_lsu_lane.sv
// Load lane extraction: shifts the raw memory word down to the accessed
// byte offset and sign- or zero-extends the selected byte/half/word.
module la_lsu_lane
    import la_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_off, 3'b000};

    // Keep only the accessed bytes and extend them to a full word.
    always_comb begin
        // NOTE: default assignment first so no path leaves o_data unassigned (no latch).
        o_data = w_shifted;
        case (i_size)
            SZ_B:    o_data = {{24{w_shifted[7]  & ~i_unsigned}}, w_shifted[7:0]};
            SZ_H:    o_data = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/la_lsu_mc.sv
// Multi-cycle load/store unit for the LA32R core. Accepts one operation per
// handshake, runs it over a data-SRAM port with addr_ok/data_ok wait states,
// and returns extended load data. Every output comes from a register.
// Optional feature: define LA_LSU_ALE_CHECK_EN to report misaligned accesses
// through resp_ale; otherwise addresses are force-aligned to the access size.
module la_lsu_mc
    import la_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     reset,
    la_lsu_mc_if.slave bus
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("la_lsu_mc: DATA_W must be 32");
    end
    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("la_lsu_mc: ADDR_W must be at least 3");
    end

    state_t            r_state;
    logic              r_req_ready;
    logic              r_sram_req;
    logic              r_sram_wr;
    logic [1:0]        r_sram_size;
    logic [3:0]        r_sram_wstrb;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [31:0]       r_sram_wdata;
    logic              r_unsigned;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_ale;

    logic [1:0]        w_size;
    logic              w_store;
    logic [ADDR_W-1:0] w_addr;
    logic              w_ale_hit;
    logic [31:0]       w_load_data;

    assign w_size  = norm_size(bus.req_op[OP_SIZE_HI:OP_SIZE_LO]);
    assign w_store = bus.req_op[OP_STORE];

`ifdef LA_LSU_ALE_CHECK_EN
    assign w_addr    = bus.req_addr;
    assign w_ale_hit = is_misaligned(w_size, bus.req_addr[1:0]);
`else
    assign w_ale_hit = 1'b0;

    // Drop the low address bits a half/word access cannot use.
    always_comb begin
        w_addr = bus.req_addr;
        if (w_size == SZ_H) begin
            w_addr[0] = 1'b0;
        end else if (w_size == SZ_W) begin
            w_addr[1:0] = 2'b00;
        end
    end
`endif

    la_lsu_lane u_lane (
        .i_rdata    (bus.data_sram_rdata),
        .i_off      (r_sram_addr[1:0]),
        .i_size     (r_sram_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // Operation FSM: accept, request memory, wait for data, hold the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_sram_req   <= 1'b0;
            r_sram_wr    <= 1'b0;
            r_sram_size  <= 2'b00;
            r_sram_wstrb <= 4'b0000;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_unsigned   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_ale   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_req_ready  <= 1'b0;
                        r_sram_wr    <= w_store;
                        r_sram_size  <= w_size;
                        r_sram_wstrb <= w_store ? calc_wstrb(w_size, w_addr[1:0]) : 4'b0000;
                        r_sram_addr  <= w_addr;
                        r_sram_wdata <= w_store ? calc_wdata(w_size, bus.req_wdata) : 32'h0;
                        r_unsigned   <= bus.req_op[OP_UNSIGNED];
                        if (w_ale_hit) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'h0;
                            r_resp_ale   <= 1'b1;
                        end else begin
                            r_state    <= ST_REQ;
                            r_sram_req <= 1'b1;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.data_sram_addr_ok) begin
                        r_sram_req <= 1'b0;
                        if (bus.data_sram_data_ok) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= r_sram_wr ? 32'h0 : w_load_data;
                            r_resp_ale   <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.data_sram_data_ok) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_sram_wr ? 32'h0 : w_load_data;
                        r_resp_ale   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_ale   <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready       = r_req_ready;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_rdata      = r_resp_rdata;
    assign bus.resp_ale        = r_resp_ale;
    assign bus.data_sram_req   = r_sram_req;
    assign bus.data_sram_wr    = r_sram_wr;
    assign bus.data_sram_size  = r_sram_size;
    assign bus.data_sram_wstrb = r_sram_wstrb;
    assign bus.data_sram_addr  = r_sram_addr;
    assign bus.data_sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_la_lsu_mc.sv
// Self-checking bench for la_lsu_mc: directed cases, randomized operations
// with random wait states against a byte-level memory/extension model,
// and reset-abort sequences.
module tb_la_lsu_mc;
    import la_lsu_pkg::*;

    logic clk;
    logic reset;

    la_lsu_mc_if #(.ADDR_W(32)) bus ();

    la_lsu_mc #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [int unsigned];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_get(input int unsigned wa);
        if (!mem.exists(wa)) mem[wa] = $urandom;
        return mem[wa];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: request, memory responder with a_dly/d_dly wait
    // states, then response held r_dly cycles before it is consumed.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int a_dly, input int d_dly, input int r_dly);
        int size_n, nbytes, off, exp_lat, lat, cyc, req_cnt, wait_cnt, guard;
        bit st, uns, eale, ph_req, ph_wait, got, do_ret;
        bit ready_ok, hold_ok, drop_ok, stable_ok;
        logic [31:0] eaddr, ewdata, erdata, word, h_wdata, h_rdata;
        logic [3:0]  ewstrb;
        logic        h_ale;
        longint unsigned w64, mask, val;

        st     = op[3];
        uns    = op[2];
        size_n = (op[1:0] == 2'd3) ? 2 : int'(op[1:0]);
        nbytes = 1 << size_n;
        eale   = 1'b0;
        eaddr  = addr;
`ifdef LA_LSU_ALE_CHECK_EN
        eale = (addr % nbytes) != 0;
`else
        eaddr = addr - (addr % nbytes);
`endif
        off    = int'(eaddr % 4);
        ewstrb = '0;
        ewdata = '0;
        for (int i = 0; i < 4; i++) begin
            ewdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
            if (st && i >= off && i < off + nbytes) ewstrb[i] = 1'b1;
        end
        word = mem_get(eaddr >> 2);
        w64  = {32'h0, word};
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        val  = (w64 >> (8 * off)) & mask;
        if (!uns && val[8*nbytes-1]) val = val | ~mask;
        erdata  = (st || eale) ? 32'h0 : val[31:0];
        exp_lat = eale ? 1 : 2 + a_dly + d_dly;

        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("pre_ready", bus.req_ready, 1);

        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        tick();
        bus.req_valid = 1'b0;
        bus.req_op    = 4'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;

        h_wdata = bus.data_sram_wdata;
        if (!eale) begin
            check("sram_req", bus.data_sram_req, 1);
            check("sram_addr", bus.data_sram_addr, eaddr);
            check("sram_wr", bus.data_sram_wr, st);
            check("sram_size", bus.data_sram_size, size_n);
            check("sram_wstrb", bus.data_sram_wstrb, ewstrb);
            if (st) check("sram_wdata", bus.data_sram_wdata, ewdata);
        end

        cyc = 1; got = 0; lat = -1; ph_req = !eale; ph_wait = 0;
        req_cnt = 0; wait_cnt = 0; ready_ok = 1; hold_ok = 1; drop_ok = 1;
        while (!got && cyc <= exp_lat + 16) begin
            bus.data_sram_addr_ok = 1'b0;
            bus.data_sram_data_ok = 1'b0;
            bus.data_sram_rdata   = $urandom;
            do_ret = 0;
            if (bus.req_ready !== 1'b0) ready_ok = 0;
            if (bus.resp_valid === 1'b1) begin
                got = 1;
                lat = cyc;
            end else begin
                if (ph_req) begin
                    if (bus.data_sram_req !== 1'b1 || bus.data_sram_addr !== eaddr ||
                        bus.data_sram_wr !== st || bus.data_sram_size !== 2'(size_n) ||
                        bus.data_sram_wstrb !== ewstrb || bus.data_sram_wdata !== h_wdata)
                        hold_ok = 0;
                    if (req_cnt == a_dly) begin
                        bus.data_sram_addr_ok = 1'b1;
                        ph_req = 0;
                        if (d_dly == 0) do_ret = 1;
                        else begin
                            ph_wait  = 1;
                            wait_cnt = 0;
                        end
                    end else begin
                        req_cnt++;
                    end
                end else begin
                    if (bus.data_sram_req !== 1'b0) drop_ok = 0;
                    if (ph_wait) begin
                        wait_cnt++;
                        if (wait_cnt == d_dly) begin
                            do_ret  = 1;
                            ph_wait = 0;
                        end
                    end
                end
                if (do_ret) begin
                    bus.data_sram_data_ok = 1'b1;
                    if (st) begin
                        for (int i = 0; i < 4; i++)
                            if (ewstrb[i]) word[8*i +: 8] = ewdata[8*i +: 8];
                        mem[eaddr >> 2] = word;
                    end else begin
                        bus.data_sram_rdata = word;
                    end
                end
                tick();
                cyc++;
            end
        end
        bus.data_sram_addr_ok = 1'b0;
        bus.data_sram_data_ok = 1'b0;

        check("latency", lat, exp_lat);
        check("ready_low", ready_ok, 1);
        check("req_drop", drop_ok, 1);
        if (!eale) check("req_hold", hold_ok, 1);
        if (got) begin
            if (!eale) check("rdata", bus.resp_rdata, erdata);
            check("ale", bus.resp_ale, eale);
            h_rdata   = bus.resp_rdata;
            h_ale     = bus.resp_ale;
            stable_ok = 1;
            for (int k = 0; k < r_dly; k++) begin
                bus.data_sram_data_ok = 1'($urandom);
                bus.data_sram_rdata   = $urandom;
                tick();
                if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== h_rdata ||
                    bus.resp_ale !== h_ale || bus.req_ready !== 1'b0)
                    stable_ok = 0;
            end
            bus.data_sram_data_ok = 1'b0;
            if (r_dly > 0) check("resp_hold", stable_ok, 1);
            bus.resp_ready = 1'b1;
            tick();
            bus.resp_ready = 1'b0;
            check("resp_done", bus.resp_valid, 0);
            check("idle_ready", bus.req_ready, 1);
        end
    endtask

    initial begin
        reset                 = 1'b1;
        bus.req_valid         = 1'b0;
        bus.req_op            = '0;
        bus.req_addr          = '0;
        bus.req_wdata         = '0;
        bus.resp_ready        = 1'b0;
        bus.data_sram_addr_ok = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = '0;
        repeat (3) tick();

        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_ale", bus.resp_ale, 0);
        check("rst_sram_req", bus.data_sram_req, 0);
        check("rst_sram_wr", bus.data_sram_wr, 0);
        check("rst_sram_size", bus.data_sram_size, 0);
        check("rst_sram_wstrb", bus.data_sram_wstrb, 0);
        check("rst_sram_addr", bus.data_sram_addr, 0);
        check("rst_sram_wdata", bus.data_sram_wdata, 0);

        reset = 1'b0;
        tick();
        check("post_rst_ready", bus.req_ready, 1);

        // Directed cases
        mem[32'h1c000100 >> 2] = 32'h80FF7F01;
        do_op(4'b0010, 32'h1c000100, 32'h0, 0, 0, 0);          // ld.w, zero wait
        do_op(4'b0000, 32'h1c000103, 32'h0, 0, 0, 1);          // ld.b
        do_op(4'b0100, 32'h1c000103, 32'h0, 0, 1, 0);          // ld.bu
        do_op(4'b0001, 32'h1c000102, 32'h0, 1, 0, 0);          // ld.h
        do_op(4'b1001, 32'h1c000102, 32'h1234ABCD, 0, 5, 0);   // st.h, slow ack
        do_op(4'b0010, 32'h1c000100, 32'h0, 3, 0, 2);          // addr_ok withheld
        do_op(4'b0010, 32'h1c000102, 32'h0, 0, 0, 0);          // misaligned ld.w
        do_op(4'b1000, 32'h1c000101, 32'hDEADBE5A, 1, 2, 0);   // st.b
        do_op(4'b0101, 32'h1c000100, 32'h0, 0, 0, 0);          // ld.hu

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            do_op(4'($urandom), 32'h1c000100 + $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset while a request is outstanding: req must drop without a clock
        bus.req_valid = 1'b1;
        bus.req_op    = 4'b0010;
        bus.req_addr  = 32'h1c000104;
        tick();
        bus.req_valid = 1'b0;
        check("abort_req_up", bus.data_sram_req, 1);
        reset = 1'b1;
        #1;
        check("async_req_drop", bus.data_sram_req, 0);
        check("abort_ready_low", bus.req_ready, 0);
        tick();
        reset = 1'b0;
        tick();
        check("abort_ready", bus.req_ready, 1);

        // Reset in WAIT, then a stray data_ok after release
        bus.req_valid = 1'b1;
        bus.req_op    = 4'b0010;
        bus.req_addr  = 32'h1c000108;
        tick();
        bus.req_valid         = 1'b0;
        bus.data_sram_addr_ok = 1'b1;
        tick();
        bus.data_sram_addr_ok = 1'b0;
        check("wait_state", 32'(dut.r_state), 32'(ST_WAIT));
        reset = 1'b1;
        tick();
        reset                 = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = $urandom;
        tick();
        bus.data_sram_data_ok = 1'b0;
        check("late_dok_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("late_dok_valid", bus.resp_valid, 0);
        check("late_dok_ready", bus.req_ready, 1);
        tick();
        check("late_dok_valid2", bus.resp_valid, 0);

        do_op(4'b0010, 32'h1c000100, 32'h0, 0, 1, 0);          // recovery

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/la_lsu_mc.md
# la_lsu_mc

Parametrised load/store unit for the multi-cycle LA32R core, replacing the single-cycle word-only data-SRAM access in the EXE/MEM states. It accepts one memory operation per handshake from the core's EXE state, drives a data-SRAM port with request/address-ok/data-ok handshakes so memory may insert any number of wait states, and returns load data byte-aligned and sign- or zero-extended. It supports byte, half and word accesses with byte write strobes and optional address-alignment checking.

## Interface
Parameters:
- ADDR_W, 32, byte address width; at least 3.
- DATA_W, 32, fixed data width; any other value is a synthesis error.

Ports:
- clk  in  1  clock, all state on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents an operation
- req_ready  out  1  unit idle and accepts; a transfer occurs on valid&&ready
- req_op  in  4  {store, unsigned, size[1:0]}; size 0 byte, 1 half, 2 word, 3 treated as word
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  result available
- resp_ready  in  1  core consumes the result
- resp_rdata  out  32  extended load data; 0 for stores
- resp_ale  out  1  alignment exception, valid with resp_valid
- data_sram_req  out  1  memory request
- data_sram_wr  out  1  1 for store
- data_sram_size  out  2  access size
- data_sram_wstrb  out  4  byte enables; 0 on loads
- data_sram_addr  out  ADDR_W  access address
- data_sram_wdata  out  32  lane-replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  read data or write ack returned
- data_sram_rdata  in  32  raw word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On a transfer, latch op, addr and wdata. If alignment checking is on and the access is misaligned, go to RESP with resp_ale=1 and no memory access. Otherwise go to REQ.
- REQ: data_sram_req=1, and all data_sram_* outputs stay stable until addr_ok.
  - addr_ok && !data_ok: go to WAIT.
  - addr_ok && data_ok in the same cycle: capture data and go straight to RESP.
- WAIT: data_sram_req=0. On data_ok, capture data and go to RESP. The unit waits indefinitely.
- RESP: resp_valid=1 and resp_rdata/resp_ale held stable. On resp_ready, go to IDLE. req_ready stays 0 until the IDLE cycle, so there is no back-to-back acceptance.
- data_ok outside REQ/WAIT is ignored.
- Store lanes, with off = addr[1:0]:
  - wstrb: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111.
  - wdata: byte {4{b}}, half {2{h}}, word as-is.
- Load extraction: shift rdata right by 8*off, take size bits, then sign-extend, or zero-extend if unsigned.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. Byte accesses are never misaligned.

## Timing
- Reset values: req_ready=0 while reset is asserted and 1 in the first cycle after it; resp_valid=0, resp_rdata=0, resp_ale=0, data_sram_req=0, data_sram_wr=0, data_sram_size=0, data_sram_wstrb=0, data_sram_addr=0, data_sram_wdata=0; FSM in IDLE.
- All outputs are driven from registers or from state only. There is no combinational path from inputs to outputs.
- Minimum latency with zero wait states (addr_ok and data_ok in the first REQ cycle): accept at cycle 0, REQ at 1, resp_valid at 2.
- With data_ok one cycle after addr_ok: resp_valid at 3.
- Each cycle addr_ok or data_ok is late adds exactly one cycle.
- A misaligned access gives resp_valid at cycle 1.
- Reset asserted mid-operation: immediate return to IDLE and data_sram_req drops asynchronously. A late data_ok after reset is ignored.

## Configuration
- LA_LSU_ALE_CHECK_EN defined: misaligned accesses are reported through resp_ale and never reach memory.
- Not defined: resp_ale is tied to 0. The address is force-aligned (addr[0] cleared for half, addr[1:0] cleared for word) for both data_sram_addr and lane selection.

## Structure
- Package la_lsu_pkg:
  - op field positions and size encodings (SZ_B, SZ_H, SZ_W);
  - FSM state enum;
  - functions computing wstrb and the replicated wdata.
- Sub-module la_lsu_lane: combinational load extract/extend from (rdata, off, size, unsigned).
- The FSM and registers live in la_lsu_mc.

## Test plan
- ld.w at addr 0x1c000100, memory word 0x80FF7F01, addr_ok and data_ok same cycle → resp_rdata=0x80FF7F01 at cycle 2, wstrb=0.
- ld.b at 0x...103 and ld.bu at 0x...103 on that word → 0xFFFFFF80 and 0x00000080 respectively.
- st.h at 0x...102 with wdata 0x1234ABCD → wstrb=4'b1100, data_sram_wdata=0xABCDABCD; data_ok 5 cycles after addr_ok → resp_valid exactly 5 cycles later, resp_rdata=0.
- addr_ok withheld 3 cycles → data_sram_req and addr/wdata held stable throughout; one request only.
- ld.w at 0x...102 with macro defined → resp_ale=1 at cycle 1 and no data_sram_req. Without macro → data_sram_addr 0x...100, normal load.
- Assert reset in WAIT, then pulse data_ok after release → FSM is IDLE, resp_valid stays 0, and req_ready=1.
